// File: rtl/uart_sys_ctrl.sv
// System-side UART command responder: parses write/read frames from the UART
// receiver, drives the register file, and returns read data or an error byte.
module uart_sys_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    RD_TIMEOUT = 15,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE   = 8'hEE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  TX_BUSY,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_DATA_VLD,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD
);

    localparam int              CNT_W    = $clog2(RD_TIMEOUT + 1);
    // Last wait cycle: the counter reaches RD_TIMEOUT when leaving it
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                state_r,      state_s;
    logic [CNT_W-1:0]      cnt_r,        cnt_s;
    logic [ADDR_WIDTH-1:0] rf_addr_r,    rf_addr_s;
    logic [DATA_WIDTH-1:0] rf_wr_data_r, rf_wr_data_s;
    logic                  rf_wr_en_r,   rf_wr_en_s;
    logic                  rf_rd_en_r,   rf_rd_en_s;
    logic [DATA_WIDTH-1:0] tx_p_data_r,  tx_p_data_s;
    logic                  tx_d_vld_r,   tx_d_vld_s;

    // Next-state and next-output decode; strobes default low, data holds
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        rf_addr_s    = rf_addr_r;
        rf_wr_data_s = rf_wr_data_r;
        rf_wr_en_s   = 1'b0;
        rf_rd_en_s   = 1'b0;
        tx_p_data_s  = tx_p_data_r;
        tx_d_vld_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (RX_D_VLD && (RX_P_DATA == WR_CMD)) begin
                    state_s = WR_ADDR;
                end else if (RX_D_VLD && (RX_P_DATA == RD_CMD)) begin
                    state_s = RD_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s   = WR_DATA;
                end else begin
                    state_s   = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_data_s = RX_P_DATA;
                    rf_wr_en_s   = 1'b1;
                    state_s      = IDLE;
                end else begin
                    state_s      = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_s = 1'b1;
                    cnt_s      = {CNT_W{1'b0}};
                    state_s    = RD_WAIT;
                end else begin
                    state_s    = RD_ADDR;
                end
            end
            RD_WAIT: begin
                // Returned data takes priority over an expiring timeout
                if (RF_RD_DATA_VLD) begin
                    tx_p_data_s = RF_RD_DATA;
                    state_s     = TX_SEND;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s       = cnt_r + CNT_W'(1);
                    tx_p_data_s = ERR_BYTE;
                    state_s     = TX_SEND;
                end else begin
                    cnt_s       = cnt_r + CNT_W'(1);
                    state_s     = RD_WAIT;
                end
            end
            TX_SEND: begin
                if (!TX_BUSY) begin
                    tx_d_vld_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s    = TX_SEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, timeout counter and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            rf_addr_r    <= {ADDR_WIDTH{1'b0}};
            rf_wr_data_r <= {DATA_WIDTH{1'b0}};
            rf_wr_en_r   <= 1'b0;
            rf_rd_en_r   <= 1'b0;
            tx_p_data_r  <= {DATA_WIDTH{1'b0}};
            tx_d_vld_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            rf_addr_r    <= rf_addr_s;
            rf_wr_data_r <= rf_wr_data_s;
            rf_wr_en_r   <= rf_wr_en_s;
            rf_rd_en_r   <= rf_rd_en_s;
            tx_p_data_r  <= tx_p_data_s;
            tx_d_vld_r   <= tx_d_vld_s;
        end
    end

    assign RF_ADDR    = rf_addr_r;
    assign RF_WR_DATA = rf_wr_data_r;
    assign RF_WR_EN   = rf_wr_en_r;
    assign RF_RD_EN   = rf_rd_en_r;
    assign TX_P_DATA  = tx_p_data_r;
    assign TX_D_VLD   = tx_d_vld_r;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Bench for uart_sys_ctrl: table of frames with expected register-file and
// transmit strobes, checked through a scoreboard queue, plus reset sequences.
module tb_uart_sys_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       TX_BUSY;
    logic [7:0] RF_RD_DATA;
    logic       RF_RD_DATA_VLD;
    logic [3:0] RF_ADDR;
    logic [7:0] RF_WR_DATA;
    logic       RF_WR_EN;
    logic       RF_RD_EN;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;

    always #5 CLK = ~CLK;

    uart_sys_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .TX_BUSY(TX_BUSY),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA), .RF_WR_EN(RF_WR_EN),
        .RF_RD_EN(RF_RD_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    typedef struct {
        logic       has_pre;
        logic [7:0] pre;
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
        int         rd_delay;   // cycles after RF_RD_EN until data strobe, -1 = never
        logic [7:0] rd_data;
        int         busy;       // cycles TX_BUSY stays high once the response is ready
        logic       noise;      // inject stray RX bytes while waiting / sending
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        int         kind;       // 0 write strobe, 1 read strobe, 2 transmit strobe
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t  exp_q[$];
    vec_t vecs[10];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   cyc = 0;
    int   last_tx_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every strobe is matched against the oldest expected event
    always @(posedge CLK) begin
        ev_t ev;
        #1;
        cyc++;
        if (RF_WR_EN || RF_RD_EN || TX_D_VLD) begin
            check("one_strobe", 32'(RF_WR_EN) + 32'(RF_RD_EN) + 32'(TX_D_VLD), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({RF_WR_EN, RF_RD_EN, TX_D_VLD}), 32'd0);
            end else begin
                ev = exp_q.pop_front();
                if (RF_WR_EN) begin
                    check("wr_kind", 32'd0, 32'(ev.kind));
                    check("wr_addr", 32'(RF_ADDR), 32'(ev.addr));
                    check("wr_data", 32'(RF_WR_DATA), 32'(ev.data));
                end else if (RF_RD_EN) begin
                    check("rd_kind", 32'd1, 32'(ev.kind));
                    check("rd_addr", 32'(RF_ADDR), 32'(ev.addr));
                end else begin
                    check("tx_kind", 32'd2, 32'(ev.kind));
                    check("tx_data", 32'(TX_P_DATA), 32'(ev.data));
                    check("tx_not_busy", 32'(TX_BUSY), 32'd0);
                    last_tx_cyc = cyc;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic push_ev(input int kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge CLK);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int drop_cyc;
        drop_cyc = 0;
        if (v.has_pre) send_byte(v.pre);
        if (v.cmd == 8'hAA) begin
            push_ev(0, v.exp_addr, v.exp_data);
        end else begin
            push_ev(1, v.exp_addr, 8'h00);
            push_ev(2, 4'h0, v.exp_data);
        end
        TX_BUSY = (v.busy > 0);
        send_byte(v.cmd);
        send_byte(v.addr);
        if (v.cmd == 8'hAA) begin
            send_byte(v.data);
        end else begin
            for (int i = 0; i <= 16; i++) begin
                RF_RD_DATA     = v.rd_data;
                RF_RD_DATA_VLD = (i == v.rd_delay);
                RX_P_DATA      = 8'hAA;
                RX_D_VLD       = v.noise && (i == 1);
                @(negedge CLK);
                if (v.rd_delay >= 0 && i >= v.rd_delay) break;
            end
            RF_RD_DATA_VLD = 1'b0;
            RX_D_VLD       = 1'b0;
            if (v.busy > 0) begin
                RX_P_DATA = 8'hBB;
                RX_D_VLD  = v.noise;
                @(negedge CLK);
                RX_D_VLD  = 1'b0;
                repeat (v.busy - 1) @(negedge CLK);
                TX_BUSY  = 1'b0;
                drop_cyc = cyc;
            end
        end
        drain($sformatf("v%0d_drain", idx));
        if (v.busy > 0) check("busy_release_cycle", 32'(last_tx_cyc), 32'(drop_cyc + 1));
        if (v.cmd != 8'hAA) check($sformatf("v%0d_tx_hold", idx), 32'(TX_P_DATA), 32'(v.exp_data));
        repeat (4) @(negedge CLK);
        exp_q.delete();
    endtask

    initial begin
        RST = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD = 1'b0;
        TX_BUSY = 1'b0;
        RF_RD_DATA = 8'h00;
        RF_RD_DATA_VLD = 1'b0;

        //             pre?  pre    cmd    addr   data   dly rdata  busy noise  eaddr edata
        vecs[0] = '{1'b0, 8'h00, 8'hAA, 8'h05, 8'h3C,  0, 8'h00,  0, 1'b0, 4'h5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'hBB, 8'h0A, 8'h00,  3, 8'h7E,  0, 1'b0, 4'hA, 8'h7E};
        vecs[2] = '{1'b0, 8'h00, 8'hBB, 8'h03, 8'h00, -1, 8'h00,  0, 1'b0, 4'h3, 8'hEE};
        vecs[3] = '{1'b1, 8'h11, 8'hAA, 8'hF2, 8'hAA,  0, 8'h00,  0, 1'b0, 4'h2, 8'hAA};
        vecs[4] = '{1'b0, 8'h00, 8'hBB, 8'h07, 8'h00, 14, 8'h5A,  0, 1'b0, 4'h7, 8'h5A};
        vecs[5] = '{1'b0, 8'h00, 8'hBB, 8'h08, 8'h00, 15, 8'h33,  0, 1'b0, 4'h8, 8'hEE};
        vecs[6] = '{1'b0, 8'h00, 8'hBB, 8'h0C, 8'h00,  3, 8'hC3, 20, 1'b1, 4'hC, 8'hC3};
        vecs[7] = '{1'b0, 8'h00, 8'hAA, 8'hBB, 8'h55,  0, 8'h00,  0, 1'b0, 4'hB, 8'h55};
        vecs[8] = '{1'b0, 8'h00, 8'hBB, 8'hAA, 8'h00,  0, 8'h81,  0, 1'b0, 4'hA, 8'h81};
        vecs[9] = '{1'b0, 8'h00, 8'hBB, 8'h01, 8'h00,  1, 8'h9D,  0, 1'b0, 4'h1, 8'h9D};

        repeat (3) @(negedge CLK);
        check("reset_outputs",
              32'({RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

        // Reset in the middle of a write frame discards it
        send_byte(8'hAA);
        send_byte(8'h04);
        RST = 1'b0;
        #1;
        check("midreset_outputs",
              32'({RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
        repeat (2) @(negedge CLK);
        check("midreset_hold",
              32'({RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        send_byte(8'h99);
        repeat (5) @(negedge CLK);

        // Read-data strobe while idle must not reach the transmit byte
        RF_RD_DATA     = 8'h55;
        RF_RD_DATA_VLD = 1'b1;
        @(negedge CLK);
        RF_RD_DATA_VLD = 1'b0;
        repeat (3) @(negedge CLK);
        check("stray_rd_vld_ignored", 32'(TX_P_DATA), 32'd0);

        push_ev(0, 4'h6, 8'h12);
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h12);
        drain("post_reset_write_drain");
        repeat (4) @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/uart_sys_ctrl.md
Name: uart_sys_ctrl

Overview:
- Command responder at the system end of the UART link.
- Parses byte frames delivered by the UART receiver and performs register-file writes and reads.
- Returns read data, or an error byte, to the UART transmitter.
- Runs in the receive/system clock domain. Frame format: command byte, address byte, then a data byte for writes only.

Parameters:
- DATA_WIDTH, 8, width of UART bytes and register data.
- ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used.
- RD_TIMEOUT, 15, cycles to wait for RF_RD_DATA_VLD before reporting an error.
- WR_CMD, 8'hAA, write command code.
- RD_CMD, 8'hBB, read command code.
- ERR_BYTE, 8'hEE, byte transmitted on read timeout.

Ports:
- CLK  input  1  block clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- RX_P_DATA  input  DATA_WIDTH  received byte; valid when RX_D_VLD=1.
- RX_D_VLD  input  1  one-cycle strobe per received byte.
- TX_BUSY  input  1  transmitter busy; high while a frame is being sent.
- RF_RD_DATA  input  DATA_WIDTH  register-file read data.
- RF_RD_DATA_VLD  input  1  one-cycle strobe qualifying RF_RD_DATA.
- RF_ADDR  output  ADDR_WIDTH  register-file address.
- RF_WR_DATA  output  DATA_WIDTH  register-file write data.
- RF_WR_EN  output  1  one-cycle write strobe.
- RF_RD_EN  output  1  one-cycle read strobe.
- TX_P_DATA  output  DATA_WIDTH  byte to transmit.
- TX_D_VLD  output  1  one-cycle transmit request.

Behaviour:
- Reset (RST=0, asynchronous):
  - state goes to IDLE, timeout counter clears.
  - RF_ADDR=0, RF_WR_DATA=0, RF_WR_EN=0, RF_RD_EN=0, TX_P_DATA=0, TX_D_VLD=0.
  - Reset asserted mid-frame discards the frame; after release the next byte is parsed as a command.
- All outputs are registered. RF_WR_EN, RF_RD_EN and TX_D_VLD are single-cycle pulses. RF_ADDR, RF_WR_DATA and TX_P_DATA hold their last value.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - RX_D_VLD with byte==WR_CMD goes to WR_ADDR.
  - byte==RD_CMD goes to RD_ADDR.
  - any other byte is dropped; stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch RF_ADDR=byte[ADDR_WIDTH-1:0], go to WR_DATA.
- WR_DATA: on RX_D_VLD, RF_WR_DATA=byte and RF_WR_EN=1 in the next cycle; return to IDLE. Latency from data strobe to write strobe is 1 cycle.
- RD_ADDR: on RX_D_VLD, latch RF_ADDR, pulse RF_RD_EN next cycle, clear the counter, go to RD_WAIT.
- RD_WAIT:
  - RF_RD_DATA_VLD=1: capture RF_RD_DATA into TX_P_DATA, go to TX_SEND.
  - Otherwise the counter increments each cycle. When it reaches RD_TIMEOUT, TX_P_DATA=ERR_BYTE and go to TX_SEND.
  - If RF_RD_DATA_VLD arrives in the same cycle the counter reaches RD_TIMEOUT, the data wins.
- TX_SEND:
  - While TX_BUSY=1, wait.
  - On the first cycle with TX_BUSY=0, pulse TX_D_VLD for one cycle and return to IDLE.
  - TX_P_DATA stays stable until the next read response.
- Command bytes are not re-checked inside a frame: a byte equal to WR_CMD or RD_CMD arriving in WR_ADDR, WR_DATA or RD_ADDR is treated as an address or data value.
- RX_D_VLD arriving in RD_WAIT or TX_SEND is dropped and is not buffered.
- RF_RD_DATA_VLD arriving outside RD_WAIT is ignored.
- RF_WR_EN and RF_RD_EN are never asserted in the same cycle.

Test Plan:
- Write frame: bytes AA,05,3C on RX_D_VLD -> one cycle after the 3C strobe, RF_WR_EN=1, RF_ADDR=5, RF_WR_DATA=3C; state returns to IDLE.
- Read frame: bytes BB,0A; RF_RD_DATA_VLD=1 with data 7E three cycles after RF_RD_EN; TX_BUSY=0 -> RF_RD_EN pulses with RF_ADDR=A, then TX_D_VLD pulses once with TX_P_DATA=7E.
- Read timeout: bytes BB,03 with no RF_RD_DATA_VLD -> after 15 wait cycles, TX_D_VLD pulses with TX_P_DATA=EE.
- TX busy backpressure: read response ready while TX_BUSY=1 for 20 cycles -> TX_D_VLD stays 0 throughout, then pulses exactly once in the first cycle TX_BUSY=0.
- Garbage and address aliasing: bytes 11, then AA,F2,AA -> 11 ignored; write to RF_ADDR=2 with RF_WR_DATA=AA.
- Reset mid-frame: AA,04, then RST low for 2 cycles, then 99 -> no RF_WR_EN at any point, all outputs 0 during reset, 99 dropped in IDLE.
